// File: rtl/crossing_cmd_queue_pkg.sv
// Shared move codes, debounce default and command type for the crossing game input path.
package crossing_pkg;

    localparam int DEB_CYCLES_DEFAULT = 20;

    typedef enum logic [1:0] {
        CMD_CAT   = 2'd0,
        CMD_DOG   = 2'd1,
        CMD_MOUSE = 2'd2,
        CMD_CANOE = 2'd3
    } move_cmd_t;

endpackage

// File: rtl/crossing_cmd_queue_debounce.sv
// Single-button debouncer: counts cycles of raw/level disagreement and emits one press per debounced rise.
module btn_debounce_edge #(
    parameter int DEB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic          level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_d <= level;
            // Compare against the previous level so the pulse lands one edge after the flip.
            press   <= level & ~level_d;
            if (raw == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/crossing_cmd_queue.sv
// Debounced move buttons -> priority-encoded commands -> show-ahead FIFO with valid/ready to Main.
// Optional CMD_DROP_CNT_EN adds a saturating dropped-press counter output.
module crossing_cmd_queue
    import crossing_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int DEPTH      = 4
) (
    input  logic                       clk_1kHz,
    input  logic                       btn_0_out,
    input  logic [3:0]                 btn_raw,
    input  logic                       game_en,
    input  logic                       cmd_ready,
    output logic                       cmd_valid,
    output logic [1:0]                 cmd_code,
    output logic [3:0]                 btn_level,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow
`ifdef CMD_DROP_CNT_EN
    ,
    output logic [3:0]                 drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [3:0]    press;
    logic          push;
    logic          pop;
    logic          full;
    logic          do_push;
    logic          drop;
    move_cmd_t     new_cmd;
    move_cmd_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce_edge #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk   (clk_1kHz),
            .rst   (btn_0_out),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .press (press[i])
        );
    end

    always_comb begin
        new_cmd = CMD_CANOE;
        if (press[3])      new_cmd = CMD_CAT;
        else if (press[2]) new_cmd = CMD_DOG;
        else if (press[1]) new_cmd = CMD_MOUSE;
    end

    assign cmd_valid  = (count != '0);
    assign cmd_code   = cmd_valid ? mem[rd_ptr] : CMD_CAT;
    assign fifo_level = count;
    assign full       = (count == LW'(DEPTH));
    assign push       = game_en & (|press);
    assign pop        = cmd_valid & cmd_ready;
    assign do_push    = push & (~full | pop);
    assign drop       = push & full & ~pop;

    always_ff @(posedge clk_1kHz) begin
        if (btn_0_out || !game_en) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= drop;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: cmd_code is masked whenever the FIFO is empty.
    always_ff @(posedge clk_1kHz) begin
        if (!btn_0_out && do_push) mem[wr_ptr] <= new_cmd;
    end

`ifdef CMD_DROP_CNT_EN
    always_ff @(posedge clk_1kHz) begin
        if (btn_0_out || !game_en) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 4'd15) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_crossing_cmd_queue.sv
// Directed bench for crossing_cmd_queue with DEB_CYCLES=20, DEPTH=4.
module tb_crossing_cmd_queue;

    logic       clk_1kHz = 1'b0;
    logic       btn_0_out;
    logic [3:0] btn_raw;
    logic       game_en;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic [3:0] btn_level;
    logic [2:0] fifo_level;
    logic       overflow;
`ifdef CMD_DROP_CNT_EN
    logic [3:0] drop_cnt;
`endif

    int vectors  = 0;
    int miscomp  = 0;
    int ov_count = 0;

    crossing_cmd_queue #(
        .DEB_CYCLES(20),
        .DEPTH     (4)
    ) dut (
        .clk_1kHz  (clk_1kHz),
        .btn_0_out (btn_0_out),
        .btn_raw   (btn_raw),
        .game_en   (game_en),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .btn_level (btn_level),
        .fifo_level(fifo_level),
        .overflow  (overflow)
`ifdef CMD_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk_1kHz = ~clk_1kHz;

    task automatic tick;
        @(posedge clk_1kHz);
        #1;
        if (overflow) ov_count++;
    endtask

    task automatic press_release(input logic [3:0] mask);
        btn_raw = mask;
        repeat (25) tick();
        btn_raw = 4'b0000;
        repeat (25) tick();
    endtask

    task automatic drain;
        cmd_ready = 1'b1;
        repeat (5) tick();
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset;
        btn_0_out = 1'b1;
        btn_raw   = 4'b0000;
        game_en   = 1'b1;
        cmd_ready = 1'b0;
        repeat (3) tick();
        btn_0_out = 1'b0;
        vectors++;
        if (btn_level !== 4'b0000) begin miscomp++; $display("FAIL reset_btn_level got %b want 0000", btn_level); end
        vectors++;
        if (fifo_level !== 3'd0) begin miscomp++; $display("FAIL reset_fifo_level got %0d want 0", fifo_level); end
        vectors++;
        if (cmd_valid !== 1'b0 || cmd_code !== 2'd0 || overflow !== 1'b0) begin
            miscomp++; $display("FAIL reset_outputs got valid=%b code=%0d ovf=%b want 0/0/0", cmd_valid, cmd_code, overflow);
        end
    endtask

    task automatic test_cat_latency;
        btn_raw = 4'b1000;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 19) begin
                vectors++;
                if (btn_level[3] !== 1'b0) begin miscomp++; $display("FAIL cat_level_e19 got %b want 0", btn_level[3]); end
            end
            if (e == 20) begin
                vectors++;
                if (btn_level[3] !== 1'b1) begin miscomp++; $display("FAIL cat_level_e20 got %b want 1", btn_level[3]); end
            end
            if (e == 21) begin
                vectors++;
                if (cmd_valid !== 1'b0) begin miscomp++; $display("FAIL cat_valid_e21 got %b want 0", cmd_valid); end
            end
            if (e == 22) begin
                vectors++;
                if (cmd_valid !== 1'b1 || cmd_code !== 2'd0) begin
                    miscomp++; $display("FAIL cat_cmd_e22 got valid=%b code=%0d want 1/0", cmd_valid, cmd_code);
                end
            end
        end
        vectors++;
        if (fifo_level !== 3'd1) begin miscomp++; $display("FAIL cat_held_level got %0d want 1", fifo_level); end
        btn_raw = 4'b0000;
        repeat (25) tick();
        drain();
        vectors++;
        if (fifo_level !== 3'd0) begin miscomp++; $display("FAIL cat_drained got %0d want 0", fifo_level); end
    endtask

    task automatic test_bounce;
        int bad = 0;
        for (int c = 0; c < 100; c++) begin
            btn_raw = ((c / 5) % 2 == 0) ? 4'b0100 : 4'b0000;
            tick();
            if (cmd_valid !== 1'b0 || btn_level[2] !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin miscomp++; $display("FAIL bounce_quiet got %0d bad cycles want 0", bad); end
        btn_raw = 4'b0100;
        for (int e = 1; e <= 22; e++) begin
            tick();
            if (e == 21) begin
                vectors++;
                if (cmd_valid !== 1'b0) begin miscomp++; $display("FAIL bounce_valid_e21 got %b want 0", cmd_valid); end
            end
        end
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_code !== 2'd1 || fifo_level !== 3'd1) begin
            miscomp++; $display("FAIL bounce_cmd got valid=%b code=%0d level=%0d want 1/1/1", cmd_valid, cmd_code, fifo_level);
        end
        btn_raw = 4'b0000;
        repeat (25) tick();
        drain();
    endtask

    task automatic test_overflow;
        ov_count = 0;
        cmd_ready = 1'b0;
        for (int p = 0; p < 4; p++) press_release(4'b0001);
        vectors++;
        if (fifo_level !== 3'd4 || ov_count != 0) begin
            miscomp++; $display("FAIL ovf_fill got level=%0d pulses=%0d want 4/0", fifo_level, ov_count);
        end
        press_release(4'b0001);
        vectors++;
        if (fifo_level !== 3'd4 || ov_count != 1) begin
            miscomp++; $display("FAIL ovf_fifth got level=%0d pulses=%0d want 4/1", fifo_level, ov_count);
        end
`ifdef CMD_DROP_CNT_EN
        vectors++;
        if (drop_cnt !== 4'd1) begin miscomp++; $display("FAIL ovf_drop_cnt got %0d want 1", drop_cnt); end
`endif
        cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (cmd_valid !== 1'b1 || cmd_code !== 2'd3) begin
                miscomp++; $display("FAIL ovf_drain%0d got valid=%b code=%0d want 1/3", k, cmd_valid, cmd_code);
            end
            tick();
        end
        cmd_ready = 1'b0;
        vectors++;
        if (cmd_valid !== 1'b0 || fifo_level !== 3'd0) begin
            miscomp++; $display("FAIL ovf_empty got valid=%b level=%0d want 0/0", cmd_valid, fifo_level);
        end
    endtask

    task automatic test_simultaneous;
        ov_count = 0;
        press_release(4'b1010);
        vectors++;
        if (fifo_level !== 3'd1 || cmd_code !== 2'd0 || ov_count != 0) begin
            miscomp++; $display("FAIL simul got level=%0d code=%0d pulses=%0d want 1/0/0", fifo_level, cmd_code, ov_count);
        end
        drain();
    endtask

    task automatic test_game_en;
        press_release(4'b1000);
        press_release(4'b0100);
        vectors++;
        if (fifo_level !== 3'd2) begin miscomp++; $display("FAIL gen_prefill got %0d want 2", fifo_level); end
        game_en = 1'b0;
        tick();
        game_en = 1'b1;
        vectors++;
        if (fifo_level !== 3'd0 || cmd_valid !== 1'b0) begin
            miscomp++; $display("FAIL gen_flush got level=%0d valid=%b want 0/0", fifo_level, cmd_valid);
        end
`ifdef CMD_DROP_CNT_EN
        vectors++;
        if (drop_cnt !== 4'd0) begin miscomp++; $display("FAIL gen_drop_clr got %0d want 0", drop_cnt); end
`endif
        game_en = 1'b0;
        btn_raw = 4'b0001;
        repeat (25) tick();
        vectors++;
        if (btn_level[0] !== 1'b1 || fifo_level !== 3'd0) begin
            miscomp++; $display("FAIL gen_off_press got lvl=%b fifo=%0d want 1/0", btn_level[0], fifo_level);
        end
        game_en = 1'b1;
        repeat (10) tick();
        vectors++;
        if (fifo_level !== 3'd0) begin miscomp++; $display("FAIL gen_held got %0d want 0", fifo_level); end
        btn_raw = 4'b0000;
        repeat (25) tick();
        press_release(4'b0001);
        vectors++;
        if (fifo_level !== 3'd1 || cmd_code !== 2'd3) begin
            miscomp++; $display("FAIL gen_repress got level=%0d code=%0d want 1/3", fifo_level, cmd_code);
        end
        drain();
    endtask

    task automatic test_full_pop;
        logic [1:0] exp_codes [4];
        exp_codes[0] = 2'd1;
        exp_codes[1] = 2'd2;
        exp_codes[2] = 2'd3;
        exp_codes[3] = 2'd0;
        ov_count = 0;
        press_release(4'b1000);
        press_release(4'b0100);
        press_release(4'b0010);
        press_release(4'b0001);
        btn_raw = 4'b1000;
        repeat (21) tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        vectors++;
        if (fifo_level !== 3'd4 || ov_count != 0) begin
            miscomp++; $display("FAIL fullpop got level=%0d pulses=%0d want 4/0", fifo_level, ov_count);
        end
        btn_raw = 4'b0000;
        repeat (25) tick();
        cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (cmd_valid !== 1'b1 || cmd_code !== exp_codes[k]) begin
                miscomp++; $display("FAIL fullpop_order%0d got valid=%b code=%0d want 1/%0d", k, cmd_valid, cmd_code, exp_codes[k]);
            end
            tick();
        end
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        btn_raw = 4'b1000;
        repeat (25) tick();
        btn_0_out = 1'b1;
        tick();
        btn_0_out = 1'b0;
        vectors++;
        if (fifo_level !== 3'd0 || cmd_valid !== 1'b0 || btn_level !== 4'b0000) begin
            miscomp++; $display("FAIL rstmid_clear got level=%0d valid=%b btn=%b want 0/0/0000", fifo_level, cmd_valid, btn_level);
        end
        for (int e = 1; e <= 22; e++) begin
            tick();
            if (e == 21) begin
                vectors++;
                if (cmd_valid !== 1'b0) begin miscomp++; $display("FAIL rstmid_e21 got %b want 0", cmd_valid); end
            end
        end
        vectors++;
        if (cmd_valid !== 1'b1 || cmd_code !== 2'd0 || fifo_level !== 3'd1) begin
            miscomp++; $display("FAIL rstmid_cmd got valid=%b code=%0d level=%0d want 1/0/1", cmd_valid, cmd_code, fifo_level);
        end
        btn_raw = 4'b0000;
        repeat (25) tick();
        drain();
    endtask

    initial begin
        test_reset();
        test_cat_latency();
        test_bounce();
        test_overflow();
        test_simultaneous();
        test_game_en();
        test_full_pop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

endmodule
